// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte width, character-timeout
// length and the timeout state encoding.
package uart_pkg;
  localparam int BYTE_W            = 8;
  localparam int CHAR_TIMEOUT_BITS = 40;

  typedef enum logic [1:0] {
    TO_IDLE    = 2'd0,
    TO_COUNT   = 2'd1,
    TO_EXPIRED = 2'd2
  } to_state_t;
endpackage

// File: rtl/uart_rx_timeout.sv
// Character timeout: counts bit times while data waits in the FIFO and flags
// expiry after CHAR_TIMEOUT_BITS bit times with no restart event.
module uart_rx_timeout
  import uart_pkg::*;
(
  input  logic       i_Clock,
  input  logic       rst,
  input  logic       restart,
  input  logic       empty,
  input  logic [4:0] clks_per_bit,
  output logic       expired
);
  localparam logic [5:0] LAST_BIT = 6'(CHAR_TIMEOUT_BITS);

  to_state_t  state_q, state_d;
  logic [4:0] presc_q, presc_d;
  logic [5:0] bits_q, bits_d;
  logic [4:0] presc_max;

  // A programmed value of 0 behaves like 1 clock per bit.
  assign presc_max = (clks_per_bit == 5'd0) ? 5'd0 : clks_per_bit - 5'd1;
  assign expired   = (state_q == TO_EXPIRED);

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      state_q <= TO_IDLE;
      presc_q <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bits_q  <= bits_d;
    end
  end

  // empty is the occupancy after this cycle's FIFO update.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bits_d  = bits_q;
    if (restart) begin
      presc_d = '0;
      bits_d  = '0;
      state_d = empty ? TO_IDLE : TO_COUNT;
    end else begin
      case (state_q)
        TO_IDLE: begin
          if (!empty) begin
            state_d = TO_COUNT;
            presc_d = '0;
            bits_d  = '0;
          end
        end
        TO_COUNT: begin
          if (empty) begin
            state_d = TO_IDLE;
          end else if (bits_q == LAST_BIT) begin
            state_d = TO_EXPIRED;
          end else if (presc_q >= presc_max) begin
            presc_d = '0;
            bits_d  = bits_q + 6'd1;
          end else begin
            presc_d = presc_q + 5'd1;
          end
        end
        TO_EXPIRED: begin
          if (empty) state_d = TO_IDLE;
        end
        default: state_d = TO_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with sticky overrun,
// fill-level interrupt and character timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEVEL = 8
) (
  input  logic                       i_Clock,
  input  logic                       rst,
  input  logic                       i_Rx_Done,
  input  logic [BYTE_W-1:0]          i_Rx_Byte,
  input  logic [4:0]                 i_Clks_Per_Bit,
  input  logic                       i_Rd_En,
  input  logic                       i_Flush,
  input  logic                       i_Clr_Ovr,
  output logic [BYTE_W-1:0]          o_Data,
  output logic                       o_Empty,
  output logic                       o_Full,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Overrun,
  output logic                       o_Level_Irq,
  output logic                       o_Timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LEVEL_C = CW'(LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              prev_done, strobe, rd_ok, wr_ok, ovr_set, restart;

  // Only the rising edge of the receiver strobe writes, so a long strobe
  // cannot duplicate a byte.
  assign strobe  = i_Rx_Done & ~prev_done;
  assign rd_ok   = i_Rd_En & (count != '0) & ~i_Flush;
  assign wr_ok   = strobe & ~i_Flush & ((count != DEPTH_C) | rd_ok);
  assign ovr_set = strobe & ~i_Flush & (count == DEPTH_C) & ~rd_ok;
  assign restart = i_Flush | wr_ok | rd_ok;

  always_comb begin
    count_nxt = count;
    if (i_Flush) begin
      count_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      count_nxt = count + ONE_C;
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count - ONE_C;
    end
  end

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      prev_done   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_Empty     <= 1'b1;
      o_Full      <= 1'b0;
      o_Level_Irq <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      prev_done   <= i_Rx_Done;
      count       <= count_nxt;
      o_Empty     <= (count_nxt == '0);
      o_Full      <= (count_nxt == DEPTH_C);
      o_Level_Irq <= (count_nxt >= LEVEL_C);
      if (i_Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      end
      // A fresh overrun beats a clear arriving in the same cycle.
      if (ovr_set) o_Overrun <= 1'b1;
      else if (i_Clr_Ovr) o_Overrun <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr] <= i_Rx_Byte;
  end

  assign o_Data  = o_Empty ? '0 : mem[rd_ptr];
  assign o_Count = count;

  uart_rx_timeout u_timeout (
    .i_Clock      (i_Clock),
    .rst          (rst),
    .restart      (restart),
    .empty        (count_nxt == '0),
    .clks_per_bit (i_Clks_Per_Bit),
    .expired      (o_Timeout)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue model checked every cycle plus
// literal expectations from the test plan.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int LEVEL = 8;

  logic       i_Clock = 1'b0;
  logic       rst = 1'b1;
  logic       i_Rx_Done = 1'b0;
  logic [7:0] i_Rx_Byte = '0;
  logic [4:0] i_Clks_Per_Bit = 5'd16;
  logic       i_Rd_En = 1'b0;
  logic       i_Flush = 1'b0;
  logic       i_Clr_Ovr = 1'b0;
  logic [7:0] o_Data;
  logic       o_Empty, o_Full, o_Overrun, o_Level_Irq, o_Timeout;
  logic [4:0] o_Count;

  int total = 0;
  int bad = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .LEVEL(LEVEL)) dut (
    .i_Clock        (i_Clock),
    .rst            (rst),
    .i_Rx_Done      (i_Rx_Done),
    .i_Rx_Byte      (i_Rx_Byte),
    .i_Clks_Per_Bit (i_Clks_Per_Bit),
    .i_Rd_En        (i_Rd_En),
    .i_Flush        (i_Flush),
    .i_Clr_Ovr      (i_Clr_Ovr),
    .o_Data         (o_Data),
    .o_Empty        (o_Empty),
    .o_Full         (o_Full),
    .o_Count        (o_Count),
    .o_Overrun      (o_Overrun),
    .o_Level_Irq    (o_Level_Irq),
    .o_Timeout      (o_Timeout)
  );

  // clock / reset
  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: byte queue, sticky overrun, cycles since the last restart event
  logic [7:0] mq[$];
  bit         m_prev;
  bit         m_ovr;
  int         since;

  always @(posedge i_Clock or posedge rst) begin
    bit s, rd, wr, full;
    if (rst) begin
      mq.delete();
      m_prev = 1'b0;
      m_ovr  = 1'b0;
      since  = 0;
    end else begin
      s    = i_Rx_Done && !m_prev;
      full = (mq.size() == DEPTH);
      rd   = i_Rd_En && (mq.size() > 0) && !i_Flush;
      wr   = s && !i_Flush && (!full || rd);
      if (s && !i_Flush && full && !rd) m_ovr = 1'b1;
      else if (i_Clr_Ovr) m_ovr = 1'b0;
      if (i_Flush) begin
        mq.delete();
        since = 0;
      end else begin
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(i_Rx_Byte);
        if (rd || wr) since = 0;
        else if (mq.size() > 0) since = since + 1;
        else since = 0;
      end
      m_prev = i_Rx_Done;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge i_Clock) begin
    int sz;
    int cpb;
    sz  = mq.size();
    cpb = (i_Clks_Per_Bit == 0) ? 1 : int'(i_Clks_Per_Bit);
    check("m_count", 32'(o_Count), 32'(sz));
    check("m_empty", 32'(o_Empty), 32'(sz == 0));
    check("m_full", 32'(o_Full), 32'(sz == DEPTH));
    check("m_data", 32'(o_Data), (sz > 0) ? 32'(mq[0]) : 32'h0);
    check("m_level", 32'(o_Level_Irq), 32'(sz >= LEVEL));
    check("m_overrun", 32'(o_Overrun), 32'(m_ovr));
    check("m_timeout", 32'(o_Timeout), 32'((sz > 0) && (since >= 40 * cpb + 1)));
  end

  // driver tasks
  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_Rx_Byte = b;
    i_Rx_Done = 1'b1;
    tick();
    i_Rx_Done = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    check(nm, 32'(o_Data), 32'(exp));
    i_Rd_En = 1'b1;
    tick();
    i_Rd_En = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] tbl [3];
    tbl[0] = 8'hA5; tbl[1] = 8'h3C; tbl[2] = 8'hFF;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_empty", 32'(o_Empty), 32'h1);
    check("rst_count", 32'(o_Count), 32'h0);
    check("rst_data", 32'(o_Data), 32'h0);
    check("rst_timeout", 32'(o_Timeout), 32'h0);

    for (int i = 0; i < 3; i++) push_byte(tbl[i]);
    check("three_count", 32'(o_Count), 32'd3);
    check("three_head", 32'(o_Data), 32'hA5);
    for (int i = 0; i < 3; i++) pop_chk("three_pop", tbl[i]);
    check("three_empty", 32'(o_Empty), 32'h1);

    for (int i = 0; i < 16; i++) push_byte(8'(i));
    push_byte(8'h55);
    check("ovr_full", 32'(o_Full), 32'h1);
    check("ovr_flag", 32'(o_Overrun), 32'h1);
    for (int i = 0; i < 16; i++) pop_chk("ovr_pop", 8'(i));
    check("ovr_drop_empty", 32'(o_Empty), 32'h1);

    for (int i = 0; i < 3; i++) push_byte(8'h21 + 8'(i));
    i_Rx_Byte = 8'h99;
    i_Rx_Done = 1'b1;
    i_Flush   = 1'b1;
    tick();
    i_Rx_Done = 1'b0;
    i_Flush   = 1'b0;
    check("flush_count", 32'(o_Count), 32'h0);
    check("flush_ovr_kept", 32'(o_Overrun), 32'h1);
    tick();
    i_Clr_Ovr = 1'b1;
    tick();
    i_Clr_Ovr = 1'b0;
    check("clr_ovr", 32'(o_Overrun), 32'h0);

    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    i_Rx_Byte = 8'h77;
    i_Rx_Done = 1'b1;
    i_Rd_En   = 1'b1;
    tick();
    i_Rx_Done = 1'b0;
    i_Rd_En   = 1'b0;
    check("rw_full_count", 32'(o_Count), 32'd16);
    check("rw_full_ovr", 32'(o_Overrun), 32'h0);
    tick();
    for (int i = 1; i < 16; i++) pop_chk("rw_pop", 8'h10 + 8'(i));
    pop_chk("rw_last", 8'h77);

    i_Rx_Byte = 8'h81;
    i_Rx_Done = 1'b1;
    repeat (5) tick();
    i_Rx_Done = 1'b0;
    tick();
    check("held_count", 32'(o_Count), 32'd1);
    pop_chk("held_pop", 8'h81);

    i_Rx_Byte = 8'h42;
    i_Rx_Done = 1'b1;
    tick();
    i_Rx_Done = 1'b0;
    n = 0;
    while (!o_Timeout && n < 1000) begin
      tick();
      n++;
    end
    check("timeout_cpb16", 32'(n), 32'd641);
    pop_chk("timeout_pop", 8'h42);
    check("timeout_clear", 32'(o_Timeout), 32'h0);
    tick();
    check("timeout_idle", 32'(o_Timeout), 32'h0);

    i_Clks_Per_Bit = 5'd0;
    i_Rx_Byte = 8'h43;
    i_Rx_Done = 1'b1;
    tick();
    i_Rx_Done = 1'b0;
    n = 0;
    while (!o_Timeout && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cpb0", 32'(n), 32'd41);
    pop_chk("timeout0_pop", 8'h43);
    i_Clks_Per_Bit = 5'd16;

    for (int i = 0; i < 7; i++) push_byte(8'h30 + 8'(i));
    check("level_7", 32'(o_Level_Irq), 32'h0);
    i_Rx_Byte = 8'h37;
    i_Rx_Done = 1'b1;
    tick();
    i_Rx_Done = 1'b0;
    check("level_8_count", 32'(o_Count), 32'd8);
    check("level_8", 32'(o_Level_Irq), 32'h1);
    tick();
    pop_chk("level_pop", 8'h30);
    check("level_fall_count", 32'(o_Count), 32'd7);
    check("level_fall", 32'(o_Level_Irq), 32'h0);
    pop_chk("level_pop2", 8'h31);
    pop_chk("level_pop3", 8'h32);
    check("pre_rst_count", 32'(o_Count), 32'd5);

    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(o_Count), 32'h0);
    check("async_rst_empty", 32'(o_Empty), 32'h1);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
